// File: rtl/lighthash_pkg.sv
// ----------------------------------------------------------------------------
// lighthash_pkg
//
// Shared definitions for the light_hash_des byte-serial hash core:
//   - IV                 : initial chaining value and digest whitening mask
//   - SBOX               : 4-bit substitution table used by the Feistel round
//   - state_e            : controller states (ABSORB, FINAL, DONE)
//   - N_ROUNDS           : finalization round count
//   - helper functions   : nibble substitution, 16-bit rotate, finalization key
//
// Configuration macro: LIGHTHASH_ROUNDS16_EN
//   defined   -> 16 finalization rounds
//   undefined -> 8 finalization rounds
// ----------------------------------------------------------------------------
package lighthash_pkg;

    localparam logic [31:0] IV = 32'h6745_2301;

    // Entry n is the substitution for nibble value n.
    localparam logic [3:0] SBOX [16] = '{
        4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,
        4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7
    };

    typedef enum logic [1:0] {
        ABSORB = 2'd0,
        FINAL  = 2'd1,
        DONE   = 2'd2
    } state_e;

`ifdef LIGHTHASH_ROUNDS16_EN
    localparam int unsigned N_ROUNDS = 16;
`else
    localparam int unsigned N_ROUNDS = 8;
`endif

    // Round index that completes finalization; the index counter is 4 bits,
    // which covers both the 8- and 16-round builds.
    localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS - 1);

    // Substitute each of the four nibbles independently.
    function automatic logic [15:0] sbox16(input logic [15:0] x);
        logic [15:0] y;
        y = '0;
        for (int n = 0; n < 4; n++) begin
            y[4*n +: 4] = SBOX[x[4*n +: 4]];
        end
        return y;
    endfunction

    function automatic logic [15:0] rotl16_3(input logic [15:0] x);
        return {x[12:0], x[15:13]};
    endfunction

    // Key for finalization round i: message length folded with a round
    // dependent constant so that every round, and every length, differs.
    function automatic logic [15:0] final_key(input logic [15:0] len16,
                                              input logic [3:0]  rnd);
        return len16 ^ {4'hC, rnd, 4'h3, rnd};
    endfunction

endpackage

// File: rtl/lighthash_round.sv
// ----------------------------------------------------------------------------
// lighthash_round
//
// One purely combinational DES-style 16-bit Feistel round.
//   s_in  [31:0] : state {L, R}
//   k     [15:0] : round key
//   s_out [31:0] : next state {R, L ^ f(R ^ k)}
// where f(x) = rotl16(sbox(x), 3).
// ----------------------------------------------------------------------------
module lighthash_round
    import lighthash_pkg::*;
(
    input  logic [31:0] s_in,
    input  logic [15:0] k,
    output logic [31:0] s_out
);

    logic [15:0] l_in;
    logic [15:0] r_in;
    logic [15:0] f;

    always_comb begin
        l_in  = s_in[31:16];
        r_in  = s_in[15:0];
        f     = rotl16_3(sbox16(r_in ^ k));
        s_out = {r_in, l_in ^ f};
    end

endmodule

// File: rtl/light_hash_des.sv
// ----------------------------------------------------------------------------
// light_hash_des
//
// Byte-serial 32-bit hash core built on a 16-bit Feistel round. Each accepted
// byte is absorbed with two chained rounds in a single cycle; once
// input_length bytes have arrived the core runs N_ROUNDS finalization rounds
// (one per cycle), then presents digest = state ^ IV with hash_ready held high.
// A byte strobe while the digest is presented starts a new message.
//
// Ports:
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous active-low reset
//   M_valid       in   1   byte strobe (accepted in ABSORB and DONE)
//   M             in   8   message byte
//   input_length  in  64   message length in bytes, stable for the message
//   hash_ready    out  1   digest valid (level)
//   digest        out 32   hash result, held until the next one completes
//
// Configuration macro: LIGHTHASH_ROUNDS16_EN (16 finalization rounds when
// defined, 8 otherwise; absorb is unaffected).
// ----------------------------------------------------------------------------
module light_hash_des
    import lighthash_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        M_valid,
    input  logic [7:0]  M,
    input  logic [63:0] input_length,
    output logic        hash_ready,
    output logic [31:0] digest
);

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_e      state_q,  state_d;
    logic [31:0] s_q,      s_d;
    logic [63:0] cnt_q,    cnt_d;
    logic [3:0]  rnd_q,    rnd_d;
    logic        ready_q,  ready_d;
    logic [31:0] digest_q, digest_d;

    // ------------------------------------------------------------------
    // Absorb / finalization datapath
    // ------------------------------------------------------------------
    logic        restart;     // byte arriving while a digest is presented
    logic [31:0] abs_base;    // state the absorbed byte is mixed into
    logic [7:0]  abs_cnt8;    // low byte of the count for this byte
    logic [63:0] cnt_next;    // count after this byte is accepted
    logic [15:0] k0;
    logic [15:0] k1;
    logic [15:0] k_fin;
    logic [31:0] s_mid;
    logic [31:0] s_abs;
    logic [31:0] s_fin;

    // A new message started from DONE is absorbed against IV with count 0,
    // so the first byte of every message sees the same starting point
    // regardless of what was hashed before.
    always_comb begin
        restart  = (state_q == DONE);
        abs_base = restart ? IV : s_q;
        abs_cnt8 = restart ? 8'h00 : cnt_q[7:0];
        cnt_next = restart ? 64'd1 : (cnt_q + 64'd1);
        k0       = {M, abs_cnt8};
        k1       = {abs_cnt8 ^ 8'hA5, M};
        k_fin    = final_key(input_length[15:0], rnd_q);
    end

    lighthash_round u_round_abs0 (
        .s_in  (abs_base),
        .k     (k0),
        .s_out (s_mid)
    );

    lighthash_round u_round_abs1 (
        .s_in  (s_mid),
        .k     (k1),
        .s_out (s_abs)
    );

    lighthash_round u_round_fin (
        .s_in  (s_q),
        .k     (k_fin),
        .s_out (s_fin)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a branch that
        // forgot one would otherwise infer a latch.
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        rnd_d    = rnd_q;
        ready_d  = ready_q;
        digest_d = digest_q;

        case (state_q)
            ABSORB: begin
                if (M_valid) begin
                    s_d   = s_abs;
                    cnt_d = cnt_next;
                    if (cnt_next == input_length) begin
                        state_d = FINAL;
                        rnd_d   = 4'd0;
                    end
                end else if ((cnt_q == 64'd0) && (input_length == 64'd0)) begin
                    // Empty message: nothing to absorb, finalize straight away.
                    state_d = FINAL;
                    rnd_d   = 4'd0;
                end
            end

            FINAL: begin
                // Bytes arriving here are dropped on purpose; there is no
                // backpressure to hold them off.
                s_d   = s_fin;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == LAST_ROUND) begin
                    digest_d = s_fin ^ IV;
                    ready_d  = 1'b1;
                    state_d  = DONE;
                end
            end

            DONE: begin
                if (M_valid) begin
                    s_d     = s_abs;
                    cnt_d   = cnt_next;
                    ready_d = 1'b0;
                    rnd_d   = 4'd0;
                    state_d = (input_length == 64'd1) ? FINAL : ABSORB;
                end
            end

            default: begin
                state_d = ABSORB;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ABSORB;
            s_q      <= IV;
            cnt_q    <= 64'd0;
            rnd_q    <= 4'd0;
            ready_q  <= 1'b0;
            digest_q <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples values
            // from before the edge, independent of statement order.
            state_q  <= state_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            rnd_q    <= rnd_d;
            ready_q  <= ready_d;
            digest_q <= digest_d;
        end
    end

    assign hash_ready = ready_q;
    assign digest     = digest_q;

endmodule

// File: tb/tb_light_hash_des.sv
// ----------------------------------------------------------------------------
// tb_light_hash_des
//
// Directed bench for light_hash_des. A reference model computes the digest of
// the whole accepted message with plain arithmetic and tracks, per cycle, when
// hash_ready must be high; a compare process checks the DUT against it on
// every falling edge. Directed checks pin latency, reset values and the
// reference round function itself.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_light_hash_des;

`ifdef LIGHTHASH_ROUNDS16_EN
    localparam int N = 16;
`else
    localparam int N = 8;
`endif

    localparam logic [31:0] IV_C = 32'h6745_2301;
    localparam int SBOX_T [16] = '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7};

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        M_valid = 1'b0;
    logic [7:0]  M = 8'h00;
    logic [63:0] input_length = 64'd0;
    logic        hash_ready;
    logic [31:0] digest;

    int total = 0;
    int bad   = 0;

    light_hash_des dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .M_valid      (M_valid),
        .M            (M),
        .input_length (input_length),
        .hash_ready   (hash_ready),
        .digest       (digest)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ne(input string name, input logic [63:0] act, input logic [63:0] other);
        total++;
        if (act === other) begin
            bad++;
            $display("FAIL %s: got %0h which must differ from %0h", name, act, other);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] mround(input logic [31:0] s, input logic [15:0] k);
        int unsigned x;
        int unsigned y;
        int unsigned l;
        int unsigned r;
        l = s[31:16];
        r = s[15:0];
        x = r ^ k;
        y = 0;
        for (int n = 3; n >= 0; n--) begin
            y = y * 16 + SBOX_T[(x >> (4 * n)) & 15];
        end
        y = ((y << 3) | (y >> 13)) & 16'hFFFF;
        return {16'(r), 16'(l ^ y)};
    endfunction

    function automatic logic [31:0] golden(input byte_q_t msg, input logic [63:0] len);
        logic [31:0] s;
        logic [7:0]  c;
        logic [3:0]  ii;
        s = IV_C;
        for (int j = 0; j < msg.size(); j++) begin
            c = 8'(j);
            s = mround(s, {msg[j], c});
            s = mround(s, {c ^ 8'hA5, msg[j]});
        end
        for (int i = 0; i < N; i++) begin
            ii = 4'(i);
            s = mround(s, len[15:0] ^ {4'hC, ii, 4'h3, ii});
        end
        return s ^ IV_C;
    endfunction

    // Transaction-level view: 0 = collecting bytes, 1 = finalizing with a
    // countdown of remaining rounds, 2 = digest presented.
    byte_q_t     m_msg;
    int          m_mode   = 0;
    int          m_left   = 0;
    logic        m_ready  = 1'b0;
    logic [31:0] m_digest = 32'h0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_msg.delete();
            m_mode   = 0;
            m_left   = 0;
            m_ready  = 1'b0;
            m_digest = 32'h0;
        end else begin
            case (m_mode)
                0: begin
                    if (M_valid) begin
                        m_msg.push_back(M);
                        if (64'(m_msg.size()) == input_length) begin
                            m_mode = 1;
                            m_left = N;
                        end
                    end else if (m_msg.size() == 0 && input_length == 64'd0) begin
                        m_mode = 1;
                        m_left = N;
                    end
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_digest = golden(m_msg, input_length);
                        m_ready  = 1'b1;
                        m_mode   = 2;
                    end
                end
                default: begin
                    if (M_valid) begin
                        m_msg.delete();
                        m_msg.push_back(M);
                        m_ready = 1'b0;
                        if (input_length == 64'd1) begin
                            m_mode = 1;
                            m_left = N;
                        end else begin
                            m_mode = 0;
                        end
                    end
                end
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        check("cyc_ready", hash_ready, m_ready);
        check("cyc_digest", digest, m_digest);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 ns after a rising edge)
    // ------------------------------------------------------------------
    task automatic do_reset(input logic [63:0] len);
        rst_n        = 1'b0;
        M_valid      = 1'b0;
        input_length = len;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        M       = b;
        M_valid = 1'b1;
        @(posedge clk);
        #2 M_valid = 1'b0;
    endtask

    task automatic send_msg(input byte_q_t msg, input int gap);
        for (int j = 0; j < msg.size(); j++) begin
            send_byte(msg[j]);
            if (j != msg.size() - 1) begin
                repeat (gap - 1) @(posedge clk);
                if (gap > 1) #2;
            end
        end
    endtask

    // Rising edges from now until hash_ready is seen high (bounded).
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!hash_ready && cycles < 64) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        string       txt;
        byte_q_t     msg_a;
        byte_q_t     msg_b;
        byte_q_t     msg4;
        byte_q_t     msg3;
        byte_q_t     empty_q;
        logic [31:0] d_a;
        logic [31:0] d4;
        int          lat;

        txt = "IGHTWEIGHTHASH";
        for (int i = 0; i < txt.len(); i++) msg_a.push_back(txt[i]);
        msg4.push_back(8'h00); msg4.push_back(8'hFF);
        msg4.push_back(8'h5A); msg4.push_back(8'hC3);
        msg3.push_back(8'h10); msg3.push_back(8'h20); msg3.push_back(8'h30);

        // Hand-computed single rounds pin the reference round function.
        check("pin_round_zero", mround(32'h0000_0000, 16'h0000), 32'h0000_7777);
        check("pin_round_ffff", mround(32'h1234_FFFF, 16'h0000), 32'hFFFF_A98F);
        check("pin_round_mix",  mround(32'h0000_0123, 16'h0000), 32'h0123_268F);

        // Reset values.
        do_reset(64'd14);
        check("reset_ready", hash_ready, 1'b0);
        check("reset_digest", digest, 32'h0);

        // 14-byte message, one strobe every 3 cycles.
        send_msg(msg_a, 3);
        wait_ready(lat);
        check("latency_14B", lat, N);
        check("digest_14B", digest, golden(msg_a, 64'd14));
        d_a = digest;

        // Same message again gives the same digest.
        do_reset(64'd14);
        send_msg(msg_a, 3);
        wait_ready(lat);
        check("repeat_same", digest, d_a);

        // One changed byte changes the digest.
        msg_b = msg_a;
        msg_b[5] = 8'h58;
        do_reset(64'd14);
        send_msg(msg_b, 3);
        wait_ready(lat);
        check_ne("one_byte_diff", digest, d_a);
        check("digest_changed", digest, golden(msg_b, 64'd14));

        // Empty message: first edge enters finalization, N more edges finish.
        do_reset(64'd0);
        wait_ready(lat);
        check("latency_empty", lat, N + 1);
        check("digest_empty", digest, golden(empty_q, 64'd0));

        // Back-to-back strobes versus slow strobes.
        do_reset(64'd4);
        send_msg(msg4, 1);
        wait_ready(lat);
        check("latency_b2b", lat, N);
        check("digest_b2b", digest, golden(msg4, 64'd4));
        d4 = digest;
        do_reset(64'd4);
        send_msg(msg4, 3);
        wait_ready(lat);
        check("b2b_vs_slow", digest, d4);

        // A strobe during finalization is dropped.
        do_reset(64'd4);
        send_msg(msg4, 1);
        repeat (2) @(posedge clk);
        #2;
        send_byte(8'h77);
        wait_ready(lat);
        check("latency_final_strobe", lat, N - 3);
        check("final_strobe_ignored", digest, d4);

        // A strobe in DONE starts a new 3-byte message.
        input_length = 64'd3;
        send_byte(msg3[0]);
        check("done_ready_drop", hash_ready, 1'b0);
        check("done_digest_held", digest, d4);
        send_byte(msg3[1]);
        send_byte(msg3[2]);
        wait_ready(lat);
        check("latency_restart", lat, N);
        check("digest_restart", digest, golden(msg3, 64'd3));

        // Reset in the middle of finalization clears outputs at once.
        input_length = 64'd1;
        send_byte(8'hAB);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midfinal_rst_ready", hash_ready, 1'b0);
        check("midfinal_rst_digest", digest, 32'h0);
        #20 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
